// File: rtl/score_lives_ctrl.sv
// Score / lives sequencer for a frame-based game: BCD score, lives counter, respawn timer.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module score_lives_ctrl #(
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       incscore,
  input  logic       hit,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] lives,
  output logic       playing,
  output logic       game_over
`ifdef SCORE_HISCORE_EN
  ,
  output logic [3:0] hiscore0,
  output logic [3:0] hiscore1
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // PLAY  | game running, score and hits accepted
  // DYING | respawn delay counted in frame ticks
  // OVER  | no lives left, waiting for start
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] DYING = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam logic [3:0] START_L      = 4'(START_LIVES);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] score0_q, score0_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] lives_q, lives_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick;

  always_comb begin
    state_d     = state_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    vsync_d     = vsync;
    frame_tick  = vsync & ~vsync_q;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = PLAY;
          score0_d = 4'd0;
          score1_d = 4'd0;
          lives_d  = START_L;
        end
      end
      PLAY: begin
        // 99 saturates rather than wrapping
        if (incscore && !(score1_q == 4'd9 && score0_q == 4'd9)) begin
          if (score0_q == 4'd9) begin
            score0_d = 4'd0;
            score1_d = score1_q + 4'd1;
          end else begin
            score0_d = score0_q + 4'd1;
          end
        end
        if (hit) begin
          lives_d     = lives_q - 4'd1;
          frame_cnt_d = 8'd0;
          state_d     = (lives_q == 4'd1) ? OVER : DYING;
        end
      end
      DYING: begin
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q == RESPAWN_LAST) state_d = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      score0_q    <= 4'd0;
      score1_q    <= 4'd0;
      lives_q     <= 4'd0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      lives_q     <= lives_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
    end
  end

  assign score0    = score0_q;
  assign score1    = score1_q;
  assign lives     = lives_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

`ifdef SCORE_HISCORE_EN
  logic [3:0] hiscore0_q, hiscore0_d;
  logic [3:0] hiscore1_q, hiscore1_d;

  // BCD digit pairs compare correctly as plain binary
  always_comb begin
    hiscore0_d = hiscore0_q;
    hiscore1_d = hiscore1_q;
    if (state_d == OVER && state_q != OVER &&
        {score1_d, score0_d} > {hiscore1_q, hiscore0_q}) begin
      hiscore0_d = score0_d;
      hiscore1_d = score1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiscore0_q <= 4'd0;
      hiscore1_q <= 4'd0;
    end else begin
      hiscore0_q <= hiscore0_d;
      hiscore1_q <= hiscore1_d;
    end
  end

  assign hiscore0 = hiscore0_q;
  assign hiscore1 = hiscore1_q;
`endif

endmodule

// File: tb/tb_score_lives_ctrl.sv
// Self-checking bench for score_lives_ctrl against a behavioural game model.
module tb_score_lives_ctrl;

  localparam int START_LIVES    = 3;
  localparam int RESPAWN_FRAMES = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b0, vsync = 1'b0, start = 1'b0, incscore = 1'b0, hit = 1'b0;
  logic [3:0] score0, score1, lives;
  logic       playing, game_over;
`ifdef SCORE_HISCORE_EN
  logic [3:0] hiscore0, hiscore1;
`endif

  int tests = 0;
  int fails = 0;

  // model: score as plain integer, mode 0=idle 1=play 2=dying 3=over
  int m_score = 0, m_lives = 0, m_mode = 0, m_frames = 0, m_hi = 0;
  bit m_vs_prev = 0;

  score_lives_ctrl #(.START_LIVES(START_LIVES), .RESPAWN_FRAMES(RESPAWN_FRAMES)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start), .incscore(incscore), .hit(hit),
    .score0(score0), .score1(score1), .lives(lives), .playing(playing), .game_over(game_over)
`ifdef SCORE_HISCORE_EN
    , .hiscore0(hiscore0), .hiscore1(hiscore1)
`endif
  );

  always #5 clk = ~clk;

  wire [13:0] obs = {score1, score0, lives, playing, game_over};

  function automatic logic [13:0] exp_vec();
    logic [3:0] t, o, l;
    t = 4'(m_score / 10);
    o = 4'(m_score % 10);
    l = 4'(m_lives);
    return {t, o, l, (m_mode == 1), (m_mode == 3)};
  endfunction

  task automatic model_step(input bit s, input bit i, input bit h, input bit v, input bit r);
    bit tick;
    tick = v && !m_vs_prev;
    m_vs_prev = v;
    if (r) begin
      m_score = 0; m_lives = 0; m_mode = 0; m_frames = 0; m_hi = 0; m_vs_prev = 0;
    end else begin
      case (m_mode)
        0, 3: if (s) begin m_score = 0; m_lives = START_LIVES; m_mode = 1; end
        1: begin
          if (i && m_score < 99) m_score++;
          if (h) begin
            m_lives--;
            m_frames = 0;
            if (m_lives == 0) begin
              m_mode = 3;
              if (m_score > m_hi) m_hi = m_score;
            end else m_mode = 2;
          end
        end
        default: if (tick) begin
          m_frames++;
          if (m_frames == RESPAWN_FRAMES) m_mode = 1;
        end
      endcase
    end
  endtask

  task automatic cyc(input bit s, input bit i, input bit h, input bit v, input bit r);
    start = s; incscore = i; hit = h; vsync = v; reset = r;
    @(posedge clk);
    model_step(s, i, h, v, r);
    #1;
    start = 0; incscore = 0; hit = 0; reset = 0;
  endtask

  task automatic frame(input bit inc_low);
    cyc(0, 0, 0, 1, 0);
    cyc(0, inc_low, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
    tests++;
    if (obs !== 14'd0) begin
      fails++; $display("FAIL reset_state: got %h expected %h", obs, 14'd0);
    end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_start();
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (playing !== 1'b1 || lives !== 4'd3 || score1 !== 4'd0 || score0 !== 4'd0 || game_over !== 1'b0) begin
      fails++; $display("FAIL start: got %h expected play/lives3/score00", obs);
    end
  endtask

  task automatic test_score();
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) cyc(0, 0, 0, 0, 0);
    end
    tests++;
    if (score1 !== 4'd1 || score0 !== 4'd0) begin
      fails++; $display("FAIL score_10: got %0d%0d expected 10", score1, score0);
    end
    for (int k = 0; k < 90; k++) begin
      cyc(0, 1, 0, 0, 0);
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL score_count: got %h expected %h", obs, exp_vec());
      end
    end
    tests++;
    if (score1 !== 4'd9 || score0 !== 4'd9) begin
      fails++; $display("FAIL score_99: got %0d%0d expected 99", score1, score0);
    end
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (score1 !== 4'd9 || score0 !== 4'd9) begin
      fails++; $display("FAIL score_saturate: got %0d%0d expected 99", score1, score0);
    end
  endtask

  task automatic test_hit_respawn();
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    tests++;
    if (lives !== 4'd2 || playing !== 1'b0 || game_over !== 1'b0) begin
      fails++; $display("FAIL hit_dying: got %h expected lives2 not playing", obs);
    end
    for (int f = 0; f < RESPAWN_FRAMES - 1; f++) frame(f % 7 == 0);
    cyc(1, 1, 1, 0, 0);
    tests++;
    if (playing !== 1'b0 || score0 !== 4'd1 || lives !== 4'd2) begin
      fails++; $display("FAIL dying_hold: got %h expected dying score01 lives2", obs);
    end
    cyc(0, 0, 0, 1, 0);
    tests++;
    if (playing !== 1'b1 || score0 !== 4'd1 || score1 !== 4'd0) begin
      fails++; $display("FAIL respawn: got %h expected play score01", obs);
    end
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_game_over();
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int h = 0; h < 3; h++) begin
      cyc(0, 0, 1, 0, 0);
      if (h < 2) for (int f = 0; f < RESPAWN_FRAMES; f++) frame(0);
    end
    tests++;
    if (game_over !== 1'b1 || lives !== 4'd0 || playing !== 1'b0) begin
      fails++; $display("FAIL game_over: got %h expected over lives0", obs);
    end
    cyc(0, 1, 1, 0, 0);
    tests++;
    if (obs !== exp_vec() || game_over !== 1'b1) begin
      fails++; $display("FAIL over_ignore: got %h expected %h", obs, exp_vec());
    end
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (playing !== 1'b1 || lives !== 4'd3 || score1 !== 4'd0 || score0 !== 4'd0) begin
      fails++; $display("FAIL restart: got %h expected play lives3 score00", obs);
    end
  endtask

  task automatic test_same_cycle();
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) cyc(0, 1, 0, 0, 0);
    for (int h = 0; h < 2; h++) begin
      cyc(0, 0, 1, 0, 0);
      for (int f = 0; f < RESPAWN_FRAMES; f++) frame(0);
    end
    cyc(0, 1, 1, 0, 0);
    tests++;
    if (score1 !== 4'd1 || score0 !== 4'd0 || lives !== 4'd0 || game_over !== 1'b1) begin
      fails++; $display("FAIL inc_and_hit: got %h expected score10 lives0 over", obs);
    end
  endtask

  task automatic test_start_ignored();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (score0 !== 4'd2 || playing !== 1'b1) begin
      fails++; $display("FAIL start_in_play: got %h expected score02 play", obs);
    end
    cyc(0, 0, 1, 0, 0);
    frame(0);
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (playing !== 1'b0 || lives !== 4'd2 || score0 !== 4'd2) begin
      fails++; $display("FAIL start_in_dying: got %h expected dying lives2", obs);
    end
  endtask

  task automatic test_mid_reset();
    frame(0);
    cyc(0, 0, 0, 1, 1);
    tests++;
    if (obs !== 14'd0) begin
      fails++; $display("FAIL mid_reset: got %h expected 0", obs);
    end
    // a fresh game must take a full respawn: no frames carried over
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int f = 0; f < RESPAWN_FRAMES; f++) begin
      frame(0);
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL reset_respawn: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit vs;
    vs = 0;
    cyc(0, 0, 0, 0, 1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) vs = ~vs;
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
          vs, $urandom_range(0, 499) == 0);
      tests++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL random c%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
  endtask

`ifdef SCORE_HISCORE_EN
  task automatic play_to_over(input int pts);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < pts; k++) cyc(0, 1, 0, 0, 0);
    for (int h = 0; h < START_LIVES; h++) begin
      cyc(0, 0, 1, 0, 0);
      if (h < START_LIVES - 1) for (int f = 0; f < RESPAWN_FRAMES; f++) frame(0);
    end
  endtask

  task automatic test_hiscore();
    cyc(0, 0, 0, 0, 1);
    play_to_over(25);
    tests++;
    if ({hiscore1, hiscore0} !== 8'h25) begin
      fails++; $display("FAIL hiscore_g1: got %h expected 25", {hiscore1, hiscore0});
    end
    play_to_over(12);
    tests++;
    if ({hiscore1, hiscore0} !== 8'h25 || game_over !== 1'b1) begin
      fails++; $display("FAIL hiscore_g2: got %h expected 25", {hiscore1, hiscore0});
    end
    cyc(0, 0, 0, 0, 1);
    tests++;
    if ({hiscore1, hiscore0} !== 8'h00) begin
      fails++; $display("FAIL hiscore_reset: got %h expected 00", {hiscore1, hiscore0});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_score();
    test_hit_respawn();
    test_game_over();
    test_same_cycle();
    test_start_ignored();
    test_mid_reset();
    test_random();
`ifdef SCORE_HISCORE_EN
    test_hiscore();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
